// File: rtl/sram_responder_pkg.sv
// ============================================================================
// Module   : cache_definition (package)
// Brief    : Shared types and pin widths for the external SRAM responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cache_definition;

  localparam int SRAM_ADDR_BITS = 20;
  localparam int SRAM_DATA_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } sram_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_resp_array.sv
// ============================================================================
// Module   : sram_resp_array
// Brief    : 2^ADDR_W x 16 storage, byte-enabled write port, async read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_resp_array
  import cache_definition::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                      clk,
  input  logic                      i_wr_en,
  input  logic [ADDR_W-1:0]         i_wr_addr,
  input  logic [1:0]                i_wr_be,
  input  logic [SRAM_DATA_BITS-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  output logic [SRAM_DATA_BITS-1:0] o_rd_data
);

  // Contents are deliberately never reset, like the real part.
  logic [SRAM_DATA_BITS-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_wr_be[0]) r_mem[i_wr_addr][7:0]  <= i_wr_data[7:0];
      if (i_wr_be[1]) r_mem[i_wr_addr][15:8] <= i_wr_data[15:8];
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/sram_responder.sv
// ============================================================================
// Module   : sram_responder
// Brief    : Clocked model of a 16-bit async SRAM with byte lanes, read
//            latency, minimum write-pulse checking and protocol counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_responder
  import cache_definition::*;
#(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1,
  parameter int WR_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      CE_N,
  input  logic                      OE_N,
  input  logic                      WE_N,
  input  logic                      LB_N,
  input  logic                      UB_N,
  input  logic [SRAM_ADDR_BITS-1:0] mem_addr,
  inout  wire  [SRAM_DATA_BITS-1:0] mem_data,
  output logic                      err_flag,
  output logic [7:0]                err_count,
  output logic [15:0]               rd_count,
  output logic [15:0]               wr_count
);

  localparam int c_LAT_W = $clog2(RD_LATENCY + 2);
  localparam int c_WR_W  = $clog2(WR_CYCLES + 1);
  localparam logic [c_LAT_W-1:0] c_LAT_FIRE = c_LAT_W'(RD_LATENCY);
  localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);
  localparam logic [c_WR_W-1:0]  c_WR_MIN   = c_WR_W'(WR_CYCLES);
  localparam logic [c_WR_W-1:0]  c_WR_ONE   = c_WR_W'(1);

  sram_resp_state_t          r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic [c_LAT_W-1:0]        r_lat_cnt;
  logic [c_WR_W-1:0]         r_wr_cnt;
  logic [SRAM_DATA_BITS-1:0] r_wdata;
  logic [1:0]                r_be;
  logic [SRAM_DATA_BITS-1:0] r_rd_data;
  logic                      r_oe_lo;
  logic                      r_oe_hi;
  logic                      r_err_flag;
  logic [7:0]                r_err_count;
  logic [15:0]               r_rd_count;
  logic [15:0]               r_wr_count;

  logic                      w_cmd_wr;
  logic                      w_cmd_rd;
  logic                      w_same;
  logic                      w_commit;
  logic [ADDR_W-1:0]         w_addr;
  logic [SRAM_DATA_BITS-1:0] w_rd_data;
  logic                      w_unused_addr;

  // Upper address bits alias onto the implemented range.
  assign w_addr        = mem_addr[ADDR_W-1:0];
  assign w_unused_addr = ^mem_addr[SRAM_ADDR_BITS-1:ADDR_W];

  assign w_cmd_wr = !CE_N && !WE_N;
  assign w_cmd_rd = !CE_N && !OE_N && WE_N;
  assign w_same   = (w_addr == r_addr);
  assign w_commit = (r_state == WRITE) && !w_cmd_wr && (r_wr_cnt >= c_WR_MIN);

  sram_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .i_wr_en   (w_commit),
    .i_wr_addr (r_addr),
    .i_wr_be   (r_be),
    .i_wr_data (r_wdata),
    .i_rd_addr (r_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_lat_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rd_data   <= '0;
      r_oe_lo     <= 1'b0;
      r_oe_hi     <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
    end else begin
      r_err_flag <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmd_wr) begin
            r_state  <= WRITE;
            r_addr   <= w_addr;
            r_wr_cnt <= c_WR_ONE;
            r_wdata  <= mem_data;
            r_be     <= {!UB_N, !LB_N};
          end else if (w_cmd_rd) begin
            r_state   <= READ;
            r_addr    <= w_addr;
            r_lat_cnt <= c_LAT_ONE;
          end
        end

        READ: begin
          if (w_cmd_wr) begin
            r_oe_lo  <= 1'b0;
            r_oe_hi  <= 1'b0;
            r_state  <= WRITE;
            r_addr   <= w_addr;
            r_wr_cnt <= c_WR_ONE;
            r_wdata  <= mem_data;
            r_be     <= {!UB_N, !LB_N};
          end else if (w_cmd_rd) begin
            if (!w_same) begin
              r_oe_lo   <= 1'b0;
              r_oe_hi   <= 1'b0;
              r_addr    <= w_addr;
              r_lat_cnt <= c_LAT_ONE;
            end else if (r_lat_cnt < c_LAT_FIRE) begin
              r_lat_cnt <= r_lat_cnt + c_LAT_ONE;
            end else if (r_lat_cnt == c_LAT_FIRE) begin
              // Counter parks one past the fire value so the read counts once.
              r_lat_cnt  <= r_lat_cnt + c_LAT_ONE;
              r_rd_data  <= w_rd_data;
              r_oe_lo    <= !LB_N;
              r_oe_hi    <= !UB_N;
              r_rd_count <= r_rd_count + 16'd1;
            end else begin
              r_oe_lo <= !LB_N;
              r_oe_hi <= !UB_N;
            end
          end else begin
            r_oe_lo <= 1'b0;
            r_oe_hi <= 1'b0;
            r_state <= IDLE;
          end
        end

        WRITE: begin
          if (w_cmd_wr) begin
            r_wdata <= mem_data;
            r_be    <= {!UB_N, !LB_N};
            if (w_same) begin
              if (r_wr_cnt < c_WR_MIN) r_wr_cnt <= r_wr_cnt + c_WR_ONE;
            end else begin
              r_err_flag <= 1'b1;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
              r_addr   <= w_addr;
              r_wr_cnt <= c_WR_ONE;
            end
          end else begin
            if (w_commit) begin
              r_wr_count <= r_wr_count + 16'd1;
            end else begin
              r_err_flag <= 1'b1;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
            if (w_cmd_rd) begin
              r_state   <= READ;
              r_addr    <= w_addr;
              r_lat_cnt <= c_LAT_ONE;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_data[7:0]  = r_oe_lo ? r_rd_data[7:0]  : 8'hzz;
  assign mem_data[15:8] = r_oe_hi ? r_rd_data[15:8] : 8'hzz;

  assign err_flag  = r_err_flag;
  assign err_count = r_err_count;
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;

endmodule

`default_nettype wire
